led_pwm_multi: RTL
==================

Name: led_pwm_multi

Overview:
- Multi-channel LED driver; successor to the single-channel fixed-period blinker.
- Each channel has a run-time-programmable period, duty and mode (OFF/ON/BLINK/PWM), written through a simple register port from the fabric/AHB bridge.
- All channels share one prescaler; outputs drive the board RGB LEDs directly.

Parameters:
- NUM_CH, 3, number of LED channels (1..8)
- CNT_W, 24, width of per-channel counter, period and duty
- PRESCALE, 1, clk cycles per count tick (>=1)
- DEFAULT_PERIOD, 4000000, period loaded at reset (< 2**CNT_W)

Ports:
- clk  in  1  fabric clock (Sys_Clk0)
- rst_n  in  1  synchronous active-low reset
- cfg_we  in  1  config write strobe
- cfg_re  in  1  config read strobe
- cfg_ch  in  3  target channel index
- cfg_addr  in  2  register select: 0 period, 1 duty, 2 mode, 3 reserved
- cfg_wdata  in  CNT_W  write data (mode uses bits [2:0])
- cfg_rdata  out  CNT_W  read data, registered
- cfg_rvalid  out  1  one-cycle pulse, cfg_rdata valid
- led  out  NUM_CH  LED drive, registered, active-high
- wrap  out  NUM_CH  one-cycle pulse per channel on counter wrap

Behaviour:
- Reset (rst_n=0 at posedge clk): period=DEFAULT_PERIOD, duty=0, mode=BLINK, counters=0, blink state=0, prescaler=0. led, wrap, cfg_rdata and cfg_rvalid are all 0. Reset asserted mid-operation aborts everything on that edge.
- Prescaler: pre_cnt counts 0..PRESCALE-1. tick=1 when pre_cnt==PRESCALE-1. PRESCALE=1 gives tick every cycle.
- Per-channel counter, on tick:
  - if cnt>=period: cnt<=0 and wrap[i]<=1
  - else cnt<=cnt+1
  - wrap is 0 on every other cycle.
  - Cycle length is period+1 ticks.
  - Using >= gives an immediate wrap on the next tick if period is lowered below cnt.
- Modes (3-bit):
  - 0 OFF: led=0.
  - 1 ON: led=1.
  - 2 BLINK: blink state toggles on each wrap; led=blink state (half-period = period+1 ticks).
  - 3 PWM: led=(cnt<duty). duty=0 gives always off; duty>period gives always on.
  - 5..7, or 4 without the macro: decoded as OFF; the stored value reads back unchanged.
- led timing: led_q is registered from current cnt, mode, duty and blink state, so it lags the counter by one cycle.
- Config write, one cycle:
  - Period write: takes effect next tick; counter not reset.
  - Duty write: takes effect next cycle.
  - Mode write: clears that channel's cnt and blink state on the same edge; overrides a coincident tick.
- Config read: cfg_rdata and cfg_rvalid are registered one cycle after cfg_re.
  - Mode reads are zero-extended.
  - Simultaneous we+re to the same register returns the old value.
- Invalid access: cfg_ch>=NUM_CH or cfg_addr==3. Writes are ignored; reads return 0 with cfg_rvalid=1.
- Counter arithmetic: unsigned CNT_W; never exceeds period after a wrap.

Optional Feature:
- Macro: LED_PWM_BREATHE_EN.
- With the macro, mode 4 BREATHE is enabled:
  - Channel runs as PWM with effective duty = internal level register (CNT_W bits, reset 0, direction up).
  - On each wrap, level moves by the duty register value (step).
  - Going up, level saturates at period+1, then direction flips to down. Going down, level saturates at 0, then direction flips to up.
  - step=0 freezes level.
  - A mode write clears level to 0 and sets direction up.
- Without the macro: no level/direction registers; mode 4 decodes as OFF.

Decomposition:
- Package led_pwm_pkg:
  - mode constants MODE_OFF=0, MODE_ON=1, MODE_BLINK=2, MODE_PWM=3, MODE_BREATHE=4
  - cfg address constants ADDR_PERIOD, ADDR_DUTY, ADDR_MODE
  - MODE_W=3
- Sub-module led_pwm_chan: one channel (counter, blink, optional breathe, led/wrap registers). Instantiated NUM_CH times via generate; the top holds the prescaler and the config decode/readback mux.

Test Plan:
- Reset defaults: PRESCALE=1, DEFAULT_PERIOD=3, no writes. led[0] rises 5 cycles after reset release (wrap at cycle 4 of ticks, +1 register), then toggles every 4 cycles. Read mode ch0 gives 2, with cfg_rvalid 1 cycle after cfg_re.
- PWM: ch1 period=9, duty=3, mode=3. led[1] high exactly 3 of every 10 cycles. Then duty=0 gives constant 0; duty=12 gives constant 1.
- Period shrink: ch0 counting at cnt=7 with period=9; write period=4. wrap[0] on the next tick, then every 5 ticks.
- Invalid access and read-before-write:
  - Write cfg_ch=5 (NUM_CH=3): all registers unchanged.
  - Read cfg_addr=3: rdata 0, rvalid 1.
  - Same-cycle we+re on ch2 duty (old 7, new 9): rdata 7.
- Reset mid-run: PRESCALE=4, ch0 PWM period=9 duty=5; assert rst_n=0 for 1 cycle mid-period. Next cycle: led=0, wrap=0, mode reads back 2 (BLINK), period reads back DEFAULT_PERIOD.
- Breathe (LED_PWM_BREATHE_EN defined): period=3, duty(step)=2, mode=4. Level after successive wraps: 2, 4, 2, 0, 2. led high-count per 4-tick cycle tracks the level (4 means all high).
- Breathe (LED_PWM_BREATHE_EN undefined): same stimulus gives led=0 throughout.

Source files
------------

// File: rtl/led_pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : led_pwm_pkg                                                      |
// | Purpose : Shared constants for the multi-channel LED PWM driver: mode      |
// |           encodings, config register addresses and field widths.          |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package led_pwm_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ON      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_PWM     = 3'd3;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 3'd4;

  typedef enum logic [1:0] {
    ADDR_PERIOD = 2'd0,
    ADDR_DUTY   = 2'd1,
    ADDR_MODE   = 2'd2,
    ADDR_RSVD   = 2'd3
  } cfg_addr_e;

endpackage
`default_nettype wire

// File: rtl/led_pwm_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : led_pwm_multi_if                                               |
// | Purpose   : Register-port bundle between the fabric bridge and the LED     |
// |             driver.                                                        |
// | Signals   : cfg_we/cfg_re strobes, cfg_ch channel, cfg_addr register,      |
// |             cfg_wdata write data, cfg_rdata/cfg_rvalid registered readback |
// | Modports  : master (bridge side), slave (driver side)                      |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface led_pwm_multi_if #(
  parameter int CNT_W = 24
);
  logic             cfg_we;
  logic             cfg_re;
  logic [2:0]       cfg_ch;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic [CNT_W-1:0] cfg_rdata;
  logic             cfg_rvalid;

  modport master (
    output cfg_we, cfg_re, cfg_ch, cfg_addr, cfg_wdata,
    input  cfg_rdata, cfg_rvalid
  );

  modport slave (
    input  cfg_we, cfg_re, cfg_ch, cfg_addr, cfg_wdata,
    output cfg_rdata, cfg_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/led_pwm_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : led_pwm_chan                                                     |
// | Purpose : One LED channel: period counter, blink toggle, optional breathe  |
// |           level, registered led and wrap outputs.                          |
// | Ports   : clk, rst_n (sync active-low)                                     |
// |           tick_i     shared prescaler tick                                 |
// |           mode_wr_i  mode register written this cycle (restarts channel)   |
// |           period_i, duty_i, mode_i  current configuration                  |
// |           led_o      registered LED drive                                  |
// |           wrap_o     one-cycle pulse on counter wrap                       |
// | Macro   : LED_PWM_BREATHE_EN enables mode 4 (BREATHE)                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              tick_i,
  input  wire logic              mode_wr_i,
  input  wire logic [CNT_W-1:0]  period_i,
  input  wire logic [CNT_W-1:0]  duty_i,
  input  wire logic [MODE_W-1:0] mode_i,
  output logic                   led_o,
  output logic                   wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic             led_q, led_d;
  logic             wrap_q, wrap_d;
  logic             at_end;

  // >= rather than == so a period lowered below the running count wraps at once
  assign at_end = (cnt_q >= period_i);

`ifdef LED_PWM_BREATHE_EN
  // One extra bit so the upper saturation point period+1 is always representable
  logic [CNT_W:0] level_q, level_d;
  logic           dir_dn_q, dir_dn_d;
  logic [CNT_W:0] lvl_top;
  logic [CNT_W:0] lvl_up;
  logic [CNT_W:0] step;

  assign step    = {1'b0, duty_i};
  assign lvl_top = {1'b0, period_i} + (CNT_W+1)'(1);
  assign lvl_up  = level_q + step;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    wrap_d  = 1'b0;
`ifdef LED_PWM_BREATHE_EN
    level_d  = level_q;
    dir_dn_d = dir_dn_q;
`endif
    // A mode write restarts the channel and wins over a coincident tick
    if (mode_wr_i) begin
      cnt_d   = '0;
      blink_d = 1'b0;
`ifdef LED_PWM_BREATHE_EN
      level_d  = '0;
      dir_dn_d = 1'b0;
`endif
    end else if (tick_i) begin
      if (at_end) begin
        cnt_d   = '0;
        wrap_d  = 1'b1;
        blink_d = ~blink_q;
`ifdef LED_PWM_BREATHE_EN
        if (!dir_dn_q) begin
          if (lvl_up >= lvl_top) begin
            level_d  = lvl_top;
            dir_dn_d = 1'b1;
          end else begin
            level_d = lvl_up;
          end
        end else begin
          if (level_q <= step) begin
            level_d  = '0;
            dir_dn_d = 1'b0;
          end else begin
            level_d = level_q - step;
          end
        end
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // LED decode uses the present count, so led lags the counter by one cycle
  always_comb begin
    led_d = 1'b0;
    case (mode_i)
      MODE_ON:      led_d = 1'b1;
      MODE_BLINK:   led_d = blink_q;
      MODE_PWM:     led_d = (cnt_q < duty_i);
`ifdef LED_PWM_BREATHE_EN
      MODE_BREATHE: led_d = ({1'b0, cnt_q} < level_q);
`endif
      default:      led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
      led_q   <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef LED_PWM_BREATHE_EN
      level_q  <= '0;
      dir_dn_q <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
`ifdef LED_PWM_BREATHE_EN
      level_q  <= level_d;
      dir_dn_q <= dir_dn_d;
`endif
    end
  end

  assign led_o  = led_q;
  assign wrap_o = wrap_q;

endmodule
`default_nettype wire

// File: rtl/led_pwm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : led_pwm_multi                                                    |
// | Purpose : Multi-channel LED driver with per-channel period/duty/mode       |
// |           registers, a shared prescaler and registered readback.          |
// | Ports   : clk, rst_n (sync active-low)                                     |
// |           cfg   register port (led_pwm_multi_if.slave)                     |
// |           led   registered LED drive, one bit per channel                  |
// |           wrap  one-cycle pulse per channel on counter wrap                |
// | Macro   : LED_PWM_BREATHE_EN enables mode 4 (BREATHE) in every channel     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module led_pwm_multi
  import led_pwm_pkg::*;
#(
  parameter int NUM_CH         = 3,
  parameter int CNT_W          = 24,
  parameter int PRESCALE       = 1,
  parameter int DEFAULT_PERIOD = 4000000
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  led_pwm_multi_if.slave     cfg,
  output logic [NUM_CH-1:0]  led,
  output logic [NUM_CH-1:0]  wrap
);

  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tick;

  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  duty_q   [NUM_CH];
  logic [MODE_W-1:0] mode_q   [NUM_CH];
  logic [NUM_CH-1:0] mode_wr;

  logic              acc_ok;
  logic [CNT_W-1:0]  rdata_q, rdata_d;
  logic              rvalid_q;

  // Prescaler: PRESCALE=1 keeps the count at 0 and ticks every cycle
  assign tick      = (pre_cnt_q == PRE_LAST);
  assign pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);

  // Accesses to a missing channel or the reserved address are dropped
  assign acc_ok = ({1'b0, cfg.cfg_ch} < 4'(NUM_CH)) && (cfg.cfg_addr != ADDR_RSVD);

  always_comb begin
    mode_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mode_wr[i] = cfg.cfg_we && acc_ok && (cfg.cfg_addr == ADDR_MODE) &&
                   (cfg.cfg_ch == 3'(i));
    end
  end

  always_comb begin
    rdata_d = '0;
    if (acc_ok) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg.cfg_ch == 3'(i)) begin
          case (cfg.cfg_addr)
            ADDR_PERIOD: rdata_d = period_q[i];
            ADDR_DUTY:   rdata_d = duty_q[i];
            ADDR_MODE:   rdata_d = CNT_W'(mode_q[i]);
            default:     rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= CNT_W'(DEFAULT_PERIOD);
        duty_q[i]   <= '0;
        mode_q[i]   <= MODE_BLINK;
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      if (cfg.cfg_we && acc_ok) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cfg.cfg_ch == 3'(i)) begin
            case (cfg.cfg_addr)
              ADDR_PERIOD: period_q[i] <= cfg.cfg_wdata;
              ADDR_DUTY:   duty_q[i]   <= cfg.cfg_wdata;
              ADDR_MODE:   mode_q[i]   <= cfg.cfg_wdata[MODE_W-1:0];
              default:     ;
            endcase
          end
        end
      end
      // Readback samples pre-write register state, so we+re returns the old value
      rvalid_q <= cfg.cfg_re;
      if (cfg.cfg_re) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign cfg.cfg_rdata  = rdata_q;
  assign cfg.cfg_rvalid = rvalid_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_pwm_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick),
      .mode_wr_i (mode_wr[i]),
      .period_i  (period_q[i]),
      .duty_i    (duty_q[i]),
      .mode_i    (mode_q[i]),
      .led_o     (led[i]),
      .wrap_o    (wrap[i])
    );
  end

endmodule
`default_nettype wire
